// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin byte arbiter feeding a FIFO that drains into an 8N1 UART transmitter.
// Define UART_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_tx_arbiter #(
  parameter int unsigned CLK_DIV = 434,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req,
  input  logic [7:0]         cpu_data,
  output logic               cpu_gnt,
  input  logic               dbg_req,
  input  logic [7:0]         dbg_data,
  output logic               dbg_gnt,
  output logic               uart_tx,
  output logic               uart_tx_busy,
  output logic               next_bit,
  output logic               fifo_full,
  output logic               fifo_empty,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(DEPTH);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

  // Handshake: a requester holds req and data stable until it sees its gnt high
  // in a cycle; the byte is captured on the rising edge that ends that cycle.

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 prio_q, prio_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     level_q, level_d;
  logic [7:0]           fifo_mem [DEPTH];

  logic                 full_c;
  logic                 empty_c;
  logic                 cpu_gnt_c;
  logic                 dbg_gnt_c;
  logic                 push;
  logic                 pop;
  logic [7:0]           push_data;
  logic                 bit_end;

  assign full_c  = (level_q == LVL_FULL);
  assign empty_c = (level_q == '0);

  // Arbitration: prio_q=0 favours the CPU, prio_q=1 favours debug. The full
  // check uses the registered level, so a same-cycle pop never frees a slot early.
  always_comb begin
    cpu_gnt_c = 1'b0;
    dbg_gnt_c = 1'b0;
    if (rst_n && !full_c) begin
      if (cpu_req && (!prio_q || !dbg_req)) begin
        cpu_gnt_c = 1'b1;
      end else if (dbg_req) begin
        dbg_gnt_c = 1'b1;
      end
    end
  end

  assign push      = cpu_gnt_c | dbg_gnt_c;
  assign push_data = cpu_gnt_c ? cpu_data : dbg_data;
  assign pop       = (state_q == IDLE) && !empty_c;

  always_comb begin
    prio_d   = prio_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (cpu_gnt_c) begin
      prio_d = 1'b1;
    end else if (dbg_gnt_c) begin
      prio_d = 1'b0;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    tx_byte_d = tx_byte_q;
    tx_d      = tx_q;
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (!empty_c) begin
          state_d   = START;
          tx_byte_d = fifo_mem[rd_ptr_q];
          cnt_d     = '0;
          bit_idx_d = '0;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = tx_byte_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
            tx_d    = ^tx_byte_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = tx_byte_q[bit_idx_d];
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      tx_byte_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      prio_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_byte_q <= tx_byte_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      prio_q    <= prio_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
    end
  end

  // Storage needs no reset: the pointers and level alone define valid contents.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= push_data;
    end
  end

  assign cpu_gnt      = cpu_gnt_c;
  assign dbg_gnt      = dbg_gnt_c;
  assign uart_tx      = tx_q;
  assign uart_tx_busy = busy_q;
  assign next_bit     = (state_q != IDLE) && bit_end;
  assign fifo_full    = full_c;
  assign fifo_empty   = empty_c;
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (CLK_DIV=4, FIFO_AW=3): frame-level model with per-cycle compare plus directed scenarios.
module tb_uart_tx_arbiter;

  localparam int D     = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic [7:0]  cpu_data = 8'h00;
  logic        dbg_req = 1'b0;
  logic [7:0]  dbg_data = 8'h00;
  logic        cpu_gnt, dbg_gnt, uart_tx, uart_tx_busy, next_bit;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_level;

  uart_tx_arbiter #(.CLK_DIV(D), .FIFO_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_data(cpu_data), .cpu_gnt(cpu_gnt),
    .dbg_req(dbg_req), .dbg_data(dbg_data), .dbg_gnt(dbg_gnt),
    .uart_tx(uart_tx), .uart_tx_busy(uart_tx_busy), .next_bit(next_bit),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] cpu_src[$];
  logic [7:0] dbg_src[$];
  logic [7:0] exp_q[$];
  logic       cpu_gnt_s = 1'b0;
  logic       dbg_gnt_s = 1'b0;
  bit         m_busy = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_prio = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level for bit slot idx of a frame: start, 8 data LSB first, [parity], stop.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Requester drivers: hold req/data until a grant was seen in the previous cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cpu_req && cpu_gnt_s && cpu_src.size() > 0) void'(cpu_src.pop_front());
      if (dbg_req && dbg_gnt_s && dbg_src.size() > 0) void'(dbg_src.pop_front());
      if (cpu_src.size() > 0) begin cpu_req = 1'b1; cpu_data = cpu_src[0]; end
      else cpu_req = 1'b0;
      if (dbg_src.size() > 0) begin dbg_req = 1'b1; dbg_data = dbg_src[0]; end
      else dbg_req = 1'b0;
    end
  end

  // Per-cycle compare against the model, then advance the model across the coming edge.
  initial begin
    logic e_cpu, e_dbg, e_tx;
    forever begin
      @(negedge clk);
      cpu_gnt_s = cpu_gnt;
      dbg_gnt_s = dbg_gnt;
      if (!rst_n) begin
        chk("rst_gnt", {cpu_gnt, dbg_gnt}, 2'b00);
        chk("rst_line", {uart_tx, uart_tx_busy, next_bit}, 3'b100);
        chk("rst_fifo", {fifo_full, fifo_empty, fifo_level}, {2'b01, 4'd0});
        exp_q.delete();
        m_busy = 1'b0; m_t = 0; m_prio = 1'b0;
      end else begin
        e_cpu = 1'b0;
        e_dbg = 1'b0;
        if (exp_q.size() < DEPTH) begin
          if (cpu_req && (!m_prio || !dbg_req)) e_cpu = 1'b1;
          else if (dbg_req) e_dbg = 1'b1;
        end
        e_tx = m_busy ? frame_bit(m_byte, m_t / D) : 1'b1;
        chk("mon_cpu_gnt", cpu_gnt, e_cpu);
        chk("mon_dbg_gnt", dbg_gnt, e_dbg);
        chk("mon_uart_tx", uart_tx, e_tx);
        chk("mon_busy", uart_tx_busy, m_busy);
        chk("mon_next_bit", next_bit, m_busy && (m_t % D == D - 1));
        chk("mon_level", fifo_level, exp_q.size());
        chk("mon_full", fifo_full, exp_q.size() == DEPTH);
        chk("mon_empty", fifo_empty, exp_q.size() == 0);
        if (!m_busy && exp_q.size() > 0) begin
          m_byte = exp_q.pop_front();
          m_busy = 1'b1;
          m_t = 0;
        end else if (m_busy) begin
          m_t++;
          if (m_t == FRAME) m_busy = 1'b0;
        end
        if (e_cpu) begin exp_q.push_back(cpu_data); m_prio = 1'b1; end
        else if (e_dbg) begin exp_q.push_back(dbg_data); m_prio = 1'b0; end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    cpu_src.delete();
    dbg_src.delete();
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (n < budget && !(!uart_tx_busy && fifo_empty && !cpu_req && !dbg_req &&
                            cpu_src.size() == 0 && dbg_src.size() == 0)) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", {fifo_empty, uart_tx_busy, cpu_req, dbg_req}, 4'b1000);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    logic [7:0] r0, r1;
    int busy_cnt, gnt_full, bad, ngr, repeats, last;
    bit saw8, pop_seen, chk_next;
    int lvl_prev;

    // Single byte 0x55: grant in cycle 0, start bit cycles 2-5, 40 busy cycles.
    do_reset();
    pat = 8'h55;
    cpu_src.push_back(pat);
    @(negedge clk);
    chk("t1_cpu_gnt_c0", cpu_gnt, 1'b1);
    chk("t1_dbg_gnt_c0", dbg_gnt, 1'b0);
    busy_cnt = 0;
    for (int c = 1; c <= FRAME + 8; c++) begin
      @(negedge clk);
      if (c == 1) chk("t1_idle_c1", {uart_tx, uart_tx_busy}, 2'b10);
      if (c >= 2 && c <= 5) chk($sformatf("t1_start_c%0d", c), uart_tx, 1'b0);
      if (c >= 6 && c <= 37) chk($sformatf("t1_data_c%0d", c), uart_tx, pat[(c - 6) / 4]);
      if (c >= FRAME - 2 && c <= FRAME + 1) chk($sformatf("t1_stop_c%0d", c), uart_tx, 1'b1);
      if (uart_tx_busy) busy_cnt++;
    end
    chk("t1_busy_len", busy_cnt, NBITS * 4);

    // Simultaneous requests: CPU first, then debug; one idle cycle between frames.
    do_reset();
    cpu_src.push_back(8'hA1);
    dbg_src.push_back(8'hB2);
    @(negedge clk);
    chk("t2_c0_gnts", {cpu_gnt, dbg_gnt}, 2'b10);
    @(negedge clk);
    chk("t2_c1_gnts", {cpu_gnt, dbg_gnt}, 2'b01);
    r0 = 8'h00;
    r1 = 8'h00;
    for (int c = 2; c <= 3 + 2 * FRAME; c++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (c == 2 + 4 * (1 + i) + 2) r0[i] = uart_tx;
        if (c == 3 + FRAME + 4 * (1 + i) + 2) r1[i] = uart_tx;
      end
      if (c == 1 + FRAME) chk("t2_end_busy", uart_tx_busy, 1'b1);
      if (c == 2 + FRAME) chk("t2_gap", {uart_tx, uart_tx_busy}, 2'b10);
      if (c == 3 + FRAME) chk("t2_second_start", {uart_tx, uart_tx_busy}, 2'b01);
    end
    chk("t2_byte0", r0, 8'hA1);
    chk("t2_byte1", r1, 8'hB2);

    // Fill to full: level 8 in cycle 9, no grants while full, grant right after the pop.
    do_reset();
    for (int i = 0; i < 12; i++) cpu_src.push_back(8'(8'h11 * i + 3));
    saw8 = 1'b0; pop_seen = 1'b0; chk_next = 1'b0; gnt_full = 0; lvl_prev = 0;
    for (int c = 0; c < FRAME + 10; c++) begin
      @(negedge clk);
      if (chk_next) begin
        chk("t3_level_after_regrant", fifo_level, 4'd8);
        chk_next = 1'b0;
      end
      if (fifo_level == 4'd8 && !saw8) begin
        saw8 = 1'b1;
        chk("t3_full_cycle", c, 9);
        chk("t3_full_flag", fifo_full, 1'b1);
      end
      if (fifo_full && (cpu_gnt || dbg_gnt)) gnt_full++;
      if (saw8 && !pop_seen && lvl_prev == 8 && fifo_level == 4'd7) begin
        pop_seen = 1'b1;
        chk("t3_pop_cycle", c, FRAME + 3);
        chk("t3_regrant", cpu_gnt, 1'b1);
        chk_next = 1'b1;
      end
      lvl_prev = int'(fifo_level);
    end
    chk("t3_gnt_while_full", gnt_full, 0);
    chk("t3_pop_seen", pop_seen, 1'b1);

    // Reset during data bit 3 with two bytes queued.
    do_reset();
    cpu_src.push_back(8'h3C);
    cpu_src.push_back(8'h5A);
    cpu_src.push_back(8'hC3);
    for (int c = 0; c <= 19; c++) @(negedge clk);
    chk("t4_pre_busy", uart_tx_busy, 1'b1);
    chk("t4_pre_level", fifo_level, 4'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_line", {uart_tx, uart_tx_busy, next_bit}, 3'b100);
    chk("t4_rst_fifo", {fifo_full, fifo_empty, fifo_level}, {2'b01, 4'd0});
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      if (!uart_tx || uart_tx_busy || !fifo_empty) bad++;
    end
    chk("t4_silent_after_release", bad, 0);

    // Round robin with both requesters held busy.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cpu_src.push_back(8'(8'h10 + i));
      dbg_src.push_back(8'(8'h80 + i));
    end
    ngr = 0; repeats = 0; last = -1; bad = 0;
    for (int c = 0; c < 400 && ngr < 12; c++) begin
      @(negedge clk);
      if (cpu_gnt && dbg_gnt) bad++;
      if (cpu_gnt) begin
        if (ngr == 0) chk("t5_first_is_cpu", cpu_gnt, 1'b1);
        if (last == 0) repeats++;
        last = 0; ngr++;
      end else if (dbg_gnt) begin
        if (ngr == 0) chk("t5_first_is_cpu", cpu_gnt, 1'b1);
        if (last == 1) repeats++;
        last = 1; ngr++;
      end
    end
    chk("t5_grant_count", ngr, 12);
    chk("t5_repeats", repeats, 0);
    chk("t5_double_gnt", bad, 0);
    wait_idle(1000);

`ifdef UART_PARITY_EN
    // Parity: 0x07 -> parity 1, 44-cycle frame; 0x03 -> parity 0.
    do_reset();
    cpu_src.push_back(8'h07);
    busy_cnt = 0;
    for (int c = 0; c <= 50; c++) begin
      @(negedge clk);
      if (c == 40) chk("t6_parity_07", uart_tx, 1'b1);
      if (uart_tx_busy) busy_cnt++;
    end
    chk("t6_frame_len", busy_cnt, 44);
    do_reset();
    cpu_src.push_back(8'h03);
    for (int c = 0; c <= 44; c++) begin
      @(negedge clk);
      if (c == 40) chk("t6_parity_03", uart_tx, 1'b0);
    end
`endif

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
